// File: rtl/doodle_pkg.sv
// doodle_pkg: definitions shared by the doodle game blocks (jump control,
// collision, rendering).
//   jump_state_t : FSM state encodings, IDLE=0 .. OVER=4
//   BUMP_*       : bump codes produced by the collision datapath
//   DEF_*        : default launch/fall/fly speeds, frame counts and floor
//   bump_norm()  : folds the undefined bump codes 5-7 onto "no bump"
package doodle_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RISE = 3'd1,
    ST_FALL = 3'd2,
    ST_FLY  = 3'd3,
    ST_OVER = 3'd4
  } jump_state_t;

  localparam logic [2:0] BUMP_NONE   = 3'd0;
  localparam logic [2:0] BUMP_GREEN  = 3'd1;
  localparam logic [2:0] BUMP_BLUE   = 3'd2;
  localparam logic [2:0] BUMP_ORANGE = 3'd3;
  localparam logic [2:0] BUMP_YELLOW = 3'd4;

  localparam logic [4:0] DEF_GREEN_SPEED  = 5'd16;
  localparam logic [4:0] DEF_BLUE_SPEED   = 5'd28;
  localparam logic [4:0] DEF_ORANGE_SPEED = 5'd10;
  localparam logic [4:0] DEF_MAX_FALL     = 5'd24;
  localparam logic [7:0] DEF_FLY_FRAMES   = 8'd120;
  localparam logic [4:0] DEF_FLY_SPEED    = 5'd12;
  localparam logic [7:0] DEF_INV_FRAMES   = 8'd180;
  localparam logic [9:0] DEF_FLOOR_Y      = 10'd470;

  function automatic logic [2:0] bump_norm(input logic [2:0] b);
    return (b > BUMP_YELLOW) ? BUMP_NONE : b;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// frame_timer: loadable 8-bit down counter advanced once per video frame.
//   clk, rst : clock, asynchronous active-high reset (count -> 0)
//   i_tick   : frame enable; load, clear and decrement act only on a tick
//   i_load   : load i_val (beats the decrement, so a reload at expiry wins)
//   i_clr    : clear to 0 (beats load)
//   i_val    : load value
//   o_cnt    : current count
//   o_nz     : count is nonzero
module frame_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick,
  input  logic       i_load,
  input  logic       i_clr,
  input  logic [7:0] i_val,
  output logic [7:0] o_cnt,
  output logic       o_nz
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 8'd0;
    end else if (i_tick) begin
      if (i_clr)              r_cnt <= 8'd0;
      else if (i_load)        r_cnt <= i_val;
      else if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_nz  = (r_cnt != 8'd0);

endmodule

// File: rtl/jump_controller.sv
// jump_controller: vertical-motion FSM for the doodle (IDLE/RISE/FALL/FLY/OVER).
// All state and outputs advance only on frame_tick and appear one clk later.
//   clk, rst      : clock, asynchronous active-high reset
//   frame_tick    : one-cycle pulse per video frame
//   start         : begin/restart (honoured only in IDLE and OVER)
//   bump          : collision code (0 none, 1 green, 2 blue, 3 orange, 4 yellow)
//   movement      : y snap offset applied when a bump lands
//   doodle_y      : current doodle y (0 = top)
//   pickup_star   : invincibility pickup
//   state, speed_y, fly, invincible, doodle_y_next, game_over : registered outputs
// Build option: define JUMP_INVINC_EN to build the invincibility counter and
// the floor rescue; without it invincible is 0 and the floor always ends the game.
module jump_controller import doodle_pkg::*; #(
  parameter logic [4:0] GREEN_SPEED  = DEF_GREEN_SPEED,
  parameter logic [4:0] BLUE_SPEED   = DEF_BLUE_SPEED,
  parameter logic [4:0] ORANGE_SPEED = DEF_ORANGE_SPEED,
  parameter logic [4:0] MAX_FALL     = DEF_MAX_FALL,
  parameter logic [7:0] FLY_FRAMES   = DEF_FLY_FRAMES,
  parameter logic [4:0] FLY_SPEED    = DEF_FLY_SPEED,
  parameter logic [7:0] INV_FRAMES   = DEF_INV_FRAMES,
  parameter logic [9:0] FLOOR_Y      = DEF_FLOOR_Y
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [2:0] bump,
  input  logic [9:0] movement,
  input  logic [9:0] doodle_y,
  input  logic       pickup_star,
  output logic [2:0] state,
  output logic [4:0] speed_y,
  output logic       fly,
  output logic       invincible,
  output logic [9:0] doodle_y_next,
  output logic       game_over
);

  logic [2:0]  r_state;
  logic [4:0]  r_speed;
  logic        r_fly;
  logic        r_go;
  logic [9:0]  r_y;

  logic [2:0]  w_bump;
  logic        w_floor;
  logic [10:0] w_rise_diff, w_fall_sum, w_fly_diff;
  logic [9:0]  w_rise_y, w_fall_y, w_fly_y;
  logic [7:0]  w_fly_cnt;
  logic        w_fly_nz, w_fly_exit, w_fly_load;
  logic        w_inv_nz;

  assign w_bump  = bump_norm(bump);
  assign w_floor = (doodle_y >= FLOOR_Y);

  // 11-bit arithmetic so the carry/borrow bit drives the clamps
  assign w_rise_diff = {1'b0, doodle_y} - {6'd0, r_speed};
  assign w_fall_sum  = {1'b0, doodle_y} + {6'd0, r_speed};
  assign w_fly_diff  = {1'b0, doodle_y} - {6'd0, FLY_SPEED};
  assign w_rise_y    = w_rise_diff[10] ? 10'd0   : w_rise_diff[9:0];
  assign w_fall_y    = w_fall_sum[10]  ? 10'h3FF : w_fall_sum[9:0];
  assign w_fly_y     = w_fly_diff[10]  ? 10'd0   : w_fly_diff[9:0];

  // Fly counter free-runs down to 0 outside FLY, so it never leaves residue
  assign w_fly_load = frame_tick && (r_state == ST_FLY ? 1'b0 : 1'b1) &&
                      (r_state == ST_FALL) && (w_bump == BUMP_YELLOW);
  assign w_fly_exit = !w_fly_nz || (w_fly_cnt == 8'd1);

  frame_timer u_fly_timer (
    .clk    (clk),
    .rst    (rst),
    .i_tick (frame_tick),
    .i_load (w_fly_load),
    .i_clr  (1'b0),
    .i_val  (FLY_FRAMES),
    .o_cnt  (w_fly_cnt),
    .o_nz   (w_fly_nz)
  );

`ifdef JUMP_INVINC_EN
  logic       w_inv_clr;
  logic [7:0] w_inv_cnt_unused;

  // Entering OVER wipes any remaining invincibility
  assign w_inv_clr = (r_state == ST_FALL) && (w_bump == BUMP_NONE) && w_floor && !w_inv_nz;

  frame_timer u_inv_timer (
    .clk    (clk),
    .rst    (rst),
    .i_tick (frame_tick),
    .i_load (pickup_star),
    .i_clr  (w_inv_clr),
    .i_val  (INV_FRAMES),
    .o_cnt  (w_inv_cnt_unused),
    .o_nz   (w_inv_nz)
  );
`else
  logic w_star_unused;
  assign w_star_unused = pickup_star ^ (|INV_FRAMES);
  assign w_inv_nz      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_speed <= 5'd0;
      r_fly   <= 1'b0;
      r_go    <= 1'b0;
      r_y     <= 10'd0;
    end else if (frame_tick) begin
      case (r_state)
        ST_IDLE: begin
          r_y <= doodle_y;
          if (start) begin
            r_state <= ST_RISE;
            r_speed <= GREEN_SPEED;
          end
        end
        ST_RISE: begin
          r_y <= w_rise_y;
          if (r_speed <= 5'd1) begin
            r_state <= ST_FALL;
            r_speed <= 5'd0;
          end else begin
            r_speed <= r_speed - 5'd1;
          end
        end
        ST_FALL: begin
          if (w_bump != BUMP_NONE) begin
            r_y <= doodle_y + movement;
            case (w_bump)
              BUMP_GREEN:  begin r_state <= ST_RISE; r_speed <= GREEN_SPEED;  end
              BUMP_BLUE:   begin r_state <= ST_RISE; r_speed <= BLUE_SPEED;   end
              BUMP_ORANGE: begin r_state <= ST_RISE; r_speed <= ORANGE_SPEED; end
              default: begin
                r_state <= ST_FLY;
                r_speed <= FLY_SPEED;
                r_fly   <= 1'b1;
              end
            endcase
          end else if (w_floor) begin
            // Floor: bounce back up when invincible, otherwise game over
            r_y <= doodle_y;
            if (w_inv_nz) begin
              r_state <= ST_RISE;
              r_speed <= GREEN_SPEED;
            end else begin
              r_state <= ST_OVER;
              r_speed <= 5'd0;
              r_go    <= 1'b1;
            end
          end else begin
            r_y     <= w_fall_y;
            r_speed <= (r_speed >= MAX_FALL) ? MAX_FALL : r_speed + 5'd1;
          end
        end
        ST_FLY: begin
          r_y <= w_fly_y;
          if (w_fly_exit) begin
            r_state <= ST_FALL;
            r_speed <= 5'd0;
            r_fly   <= 1'b0;
          end
        end
        ST_OVER: begin
          r_y <= doodle_y;
          if (start) begin
            r_state <= ST_IDLE;
            r_go    <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_speed <= 5'd0;
          r_fly   <= 1'b0;
          r_go    <= 1'b0;
          r_y     <= doodle_y;
        end
      endcase
    end
  end

  assign state         = r_state;
  assign speed_y       = r_speed;
  assign fly           = r_fly;
  assign game_over     = r_go;
  assign doodle_y_next = r_y;
  assign invincible    = w_inv_nz;

endmodule

// File: tb/tb_jump_controller.sv
module tb_jump_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick, start, pickup_star;
  logic [2:0] bump;
  logic [9:0] movement, doodle_y;
  logic [2:0] state;
  logic [4:0] speed_y;
  logic       fly, invincible, game_over;
  logic [9:0] doodle_y_next;

  jump_controller dut (
    .clk           (clk),
    .rst           (rst),
    .frame_tick    (frame_tick),
    .start         (start),
    .bump          (bump),
    .movement      (movement),
    .doodle_y      (doodle_y),
    .pickup_star   (pickup_star),
    .state         (state),
    .speed_y       (speed_y),
    .fly           (fly),
    .invincible    (invincible),
    .doodle_y_next (doodle_y_next),
    .game_over     (game_over)
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;

  // Reference model: game state as plain integers
  int m_st, m_sp, m_y, m_fc, m_ic;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_sp = 0; m_y = 0; m_fc = 0; m_ic = 0;
  endtask

  task automatic model_tick(input bit st, input int b, input int mv, input int dy, input bit star);
    int ns, nsp, ny, nfc, bb;
    bit inv;
    ns  = m_st;
    nsp = m_sp;
    ny  = m_y;
    inv = (m_ic > 0);
    nfc = (m_fc > 0) ? m_fc - 1 : 0;
    case (m_st)
      0: begin
        ny = dy;
        if (st) begin ns = 1; nsp = 16; end
      end
      1: begin
        ny = (dy - m_sp < 0) ? 0 : dy - m_sp;
        if (m_sp <= 1) begin ns = 2; nsp = 0; end
        else nsp = m_sp - 1;
      end
      2: begin
        bb = (b > 4) ? 0 : b;
        if (bb != 0) begin
          ny = (dy + mv) % 1024;
          case (bb)
            1: begin ns = 1; nsp = 16; end
            2: begin ns = 1; nsp = 28; end
            3: begin ns = 1; nsp = 10; end
            default: begin ns = 3; nsp = 12; nfc = 120; end
          endcase
        end else if (dy >= 470) begin
          ny = dy;
          if (inv) begin ns = 1; nsp = 16; end
          else begin ns = 4; nsp = 0; end
        end else begin
          ny  = (dy + m_sp > 1023) ? 1023 : dy + m_sp;
          nsp = (m_sp + 1 > 24) ? 24 : m_sp + 1;
        end
      end
      3: begin
        ny = (dy - 12 < 0) ? 0 : dy - 12;
        if (m_fc <= 1) begin ns = 2; nsp = 0; end
      end
      4: begin
        ny = dy;
        if (st) ns = 0;
      end
      default: begin ns = 0; nsp = 0; ny = dy; end
    endcase
`ifdef JUMP_INVINC_EN
    if (ns == 4 && m_st != 4) m_ic = 0;
    else if (star)            m_ic = 180;
    else if (m_ic > 0)        m_ic = m_ic - 1;
`else
    m_ic = 0;
`endif
    m_st = ns; m_sp = nsp; m_y = ny; m_fc = nfc;
  endtask

  task automatic check_all();
    chk("state", state, m_st);
    chk("speed_y", speed_y, m_sp);
    chk("fly", fly, (m_st == 3) ? 1 : 0);
    chk("invincible", invincible, (m_ic > 0) ? 1 : 0);
    chk("doodle_y_next", doodle_y_next, m_y);
    chk("game_over", game_over, (m_st == 4) ? 1 : 0);
  endtask

  task automatic step(input bit tk, input bit st, input int b, input int mv, input int dy, input bit star);
    @(negedge clk);
    frame_tick  = tk;
    start       = st;
    bump        = b[2:0];
    movement    = mv[9:0];
    doodle_y    = dy[9:0];
    pickup_star = star;
    if (tk) model_tick(st, b, mv, dy, star);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_speed"}, speed_y, 0);
    chk({tag, "_fly"}, fly, 0);
    chk({tag, "_inv"}, invincible, 0);
    chk({tag, "_ynext"}, doodle_y_next, 0);
    chk({tag, "_go"}, game_over, 0);
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    frame_tick = 0; start = 0; bump = 0; movement = 0; doodle_y = 0; pickup_star = 0;
    model_reset();
    #12;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Start and a full green rise
    step(1, 1, 0, 0, 400, 0);
    chk("r19_rise_state", state, 1);
    chk("r19_rise_speed", speed_y, 16);
    repeat (16) step(1, 0, 0, 0, m_y, 0);
    chk("r19_fall_state", state, 2);
    chk("r19_fall_speed", speed_y, 0);

    // No tick: inputs must not move anything
    step(0, 1, 2, 5, 100, 1);
    chk("no_tick_state", state, 2);

    // Blue spring with negative snap
    step(1, 0, 2, 10'h3FC, 300, 0);
    chk("r20_ynext", doodle_y_next, 296);
    chk("r20_state", state, 1);
    chk("r20_speed", speed_y, 28);
    repeat (28) step(1, 0, 0, 0, m_y, 0);

    // Yellow: FLY for exactly 120 ticks
    step(1, 0, 4, 0, 200, 0);
    chk("r21_enter_fly", fly, 1);
    cnt = 1;
    for (int i = 0; i < 120; i++) begin
      step(1, 0, 1, 0, 500, 0);
      if (fly) cnt++;
    end
    chk("r21_fly_ticks", cnt, 120);
    chk("r21_exit_state", state, 2);
    chk("r21_exit_speed", speed_y, 0);

    // Floor without invincibility ends the game, start returns to IDLE
    step(1, 0, 0, 0, 470, 0);
    chk("r22_over_state", state, 4);
    chk("r22_game_over", game_over, 1);
    step(1, 0, 0, 0, 100, 0);
    step(1, 1, 0, 0, 100, 0);
    chk("r11_restart", state, 0);

`ifdef JUMP_INVINC_EN
    // Invincibility duration and reload at expiry
    step(1, 0, 0, 0, 100, 1);
    cnt = 1;
    for (int i = 0; i < 179; i++) begin
      step(1, 0, 0, 0, 100, 0);
      if (invincible) cnt++;
    end
    chk("r23_inv_ticks", cnt, 180);
    step(1, 0, 0, 0, 100, 1);
    chk("r23_reload", invincible, 1);
    repeat (179) step(1, 0, 0, 0, 100, 0);
    chk("r23_still_inv", invincible, 1);
    step(1, 0, 0, 0, 100, 0);
    chk("r23_expired", invincible, 0);

    // Floor rescue
    step(1, 1, 0, 0, 400, 1);
    repeat (16) step(1, 0, 0, 0, m_y, 0);
    step(1, 0, 0, 0, 470, 0);
    chk("r22_rescue_state", state, 1);
    chk("r22_rescue_speed", speed_y, 16);
    repeat (16) step(1, 0, 0, 0, m_y, 0);
`endif

    // Asynchronous reset mid-FLY (and mid-invincibility when built)
    if (state == 3'd0) step(1, 1, 0, 0, 400, 1);
    else step(1, 0, 0, 0, 100, 1);
    while (m_st == 1) step(1, 0, 0, 0, m_y, 0);
    step(1, 0, 4, 0, 300, 1);
    repeat (10) step(1, 0, 0, 0, m_y, 0);
    chk("r24_pre_fly", fly, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_zero("r24_async");
    model_reset();
    #1 rst = 1'b0;
    step(1, 0, 4, 0, 300, 0);
    chk("r24_idle_holds", state, 0);

    // Randomized play
    for (int i = 0; i < 4000; i++) begin
      bit tk, st, star;
      int b, mv, dy;
      tk   = ($urandom % 4) != 0;
      st   = ($urandom % 12) == 0;
      b    = (($urandom % 4) == 0) ? int'($urandom % 8) : 0;
      mv   = int'($urandom % 1024);
      dy   = (($urandom % 6) == 0) ? int'($urandom % 1024) : m_y;
      star = ($urandom % 48) == 0;
      step(tk, st, b, mv, dy, star);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
